// File: rtl/sha_block_loader.sv
// Front-end sequencer for sha_core: packs 16 stream words big-endian into a block,
// pulses start, waits (with timeout) for the core, then holds the digest until acked.
module sha_block_loader #(
   parameter int unsigned WORD_W   = 32,
   parameter int unsigned BLOCK_W  = 512,
   parameter int unsigned DIGEST_W = 256,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [WORD_W-1:0]   s_data,
   input  logic                abort,
   output logic                core_start,
   output logic [BLOCK_W-1:0]  core_message,
   input  logic [DIGEST_W-1:0] core_hash,
   input  logic                core_valid,
   output logic [DIGEST_W-1:0] digest,
   output logic                digest_valid,
   input  logic                digest_ack,
   output logic                busy,
   output logic                error,
   output logic [3:0]          word_count
);

   localparam int unsigned N_WORDS = BLOCK_W / WORD_W;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           word_count_q, word_count_d;
   logic [BLOCK_W-1:0]   message_q, message_d;
   logic [DIGEST_W-1:0]  digest_q, digest_d;
   logic                 digest_valid_q, digest_valid_d;
   logic                 error_q, error_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 s_ready_q, s_ready_d;
   logic                 core_start_q, core_start_d;
   logic                 busy_q, busy_d;

   // Next-state and registered-output decode
   always_comb begin
      state_d        = state_q;
      word_count_d   = word_count_q;
      message_d      = message_q;
      digest_d       = digest_q;
      digest_valid_d = digest_valid_q;
      error_d        = error_q;
      cnt_d          = cnt_q;

      if (abort) begin
         state_d        = S_LOAD;
         word_count_d   = '0;
         digest_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (s_valid) begin
                  for (int unsigned k = 0; k < N_WORDS; k++) begin
                     if (word_count_q == 4'(k)) begin
                        message_d[BLOCK_W-1-WORD_W*k -: WORD_W] = s_data;
                     end
                  end
                  if (word_count_q == 4'd0) begin
                     error_d = 1'b0;
                  end
                  if (word_count_q == 4'(N_WORDS - 1)) begin
                     word_count_d = '0;
                     state_d      = S_START;
                  end else begin
                     word_count_d = word_count_q + 4'd1;
                  end
               end
            end
            S_START: begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               // cnt_q counts completed WAIT cycles; TIMEOUT cycles without valid is an error
               if (core_valid) begin
                  digest_d       = core_hash;
                  digest_valid_d = 1'b1;
                  state_d        = S_DONE;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  error_d = 1'b1;
                  state_d = S_LOAD;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (digest_ack) begin
                  digest_valid_d = 1'b0;
                  state_d        = S_LOAD;
               end
            end
            default: state_d = S_LOAD;
         endcase
      end

      s_ready_d    = (state_d == S_LOAD);
      core_start_d = (state_d == S_START);
      busy_d       = (state_d == S_START) || (state_d == S_WAIT);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q        <= S_LOAD;
         word_count_q   <= '0;
         message_q      <= '0;
         digest_q       <= '0;
         digest_valid_q <= 1'b0;
         error_q        <= 1'b0;
         cnt_q          <= '0;
         s_ready_q      <= 1'b1;
         core_start_q   <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         word_count_q   <= word_count_d;
         message_q      <= message_d;
         digest_q       <= digest_d;
         digest_valid_q <= digest_valid_d;
         error_q        <= error_d;
         cnt_q          <= cnt_d;
         s_ready_q      <= s_ready_d;
         core_start_q   <= core_start_d;
         busy_q         <= busy_d;
      end
   end

   assign s_ready      = s_ready_q;
   assign core_start   = core_start_q;
   assign core_message = message_q;
   assign digest       = digest_q;
   assign digest_valid = digest_valid_q;
   assign busy         = busy_q;
   assign error        = error_q;
   assign word_count   = word_count_q;

endmodule

// File: tb/tb_sha_block_loader.sv
// Self-checking bench for sha_block_loader: table of hash jobs plus hand-written
// sequences for timeout, abort and reset corner cases, with a core stub driven here.
module tb_sha_block_loader;

   localparam int TIMEOUT = 255;

   logic         clk = 1'b0;
   logic         clr;
   logic         s_valid;
   logic         s_ready;
   logic [31:0]  s_data;
   logic         abort;
   logic         core_start;
   logic [511:0] core_message;
   logic [255:0] core_hash;
   logic         core_valid;
   logic [255:0] digest;
   logic         digest_valid;
   logic         digest_ack;
   logic         busy;
   logic         error;
   logic [3:0]   word_count;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sha_block_loader dut (
      .clk          (clk),
      .clr          (clr),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .abort        (abort),
      .core_start   (core_start),
      .core_message (core_message),
      .core_hash    (core_hash),
      .core_valid   (core_valid),
      .digest       (digest),
      .digest_valid (digest_valid),
      .digest_ack   (digest_ack),
      .busy         (busy),
      .error        (error),
      .word_count   (word_count)
   );

   typedef struct {
      bit           gaps;
      int           vdelay;
      int           hold;
      int           ackd;
      logic [255:0] hash;
      logic [255:0] exp_digest;
   } vec_t;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r = '0;
      for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
      return r;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"}, 512'(s_ready), 512'(1));
      check({tag, "_core_start"}, 512'(core_start), 512'(0));
      check({tag, "_core_message"}, core_message, 512'(0));
      check({tag, "_digest"}, 512'(digest), 512'(0));
      check({tag, "_digest_valid"}, 512'(digest_valid), 512'(0));
      check({tag, "_busy"}, 512'(busy), 512'(0));
      check({tag, "_error"}, 512'(error), 512'(0));
      check({tag, "_word_count"}, 512'(word_count), 512'(0));
   endtask

   // Streams n words; when a full block completes, checks the start cycle and WAIT entry.
   task automatic send_words(input logic [31:0] w [16], input int n, input bit gaps,
                             output logic [511:0] exp_msg);
      int k = 0;
      int guard = 0;
      logic xfer;
      logic [511:0] m = '0;
      while (k < n) begin
         s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         s_data  = w[k];
         if (gaps) digest_ack = 1'($urandom_range(0, 1));
         check("s_ready_load", 512'(s_ready), 512'(1));
         check("core_start_load", 512'(core_start), 512'(0));
         xfer = s_valid;
         step();
         if (xfer) begin
            m = (m << 32) | 512'(w[k]);
            k++;
            check("word_count", 512'(word_count), 512'(k % 16));
            if (k == 1) check("error_cleared", 512'(error), 512'(0));
         end
         guard++;
         if (guard > 2000) begin
            check("send_timeout", 512'(k), 512'(n));
            break;
         end
      end
      digest_ack = 1'b0;
      s_valid    = 1'b0;
      exp_msg    = m;
      if (n == 16) begin
         s_valid = 1'b1;
         s_data  = 32'hdead_beef;
         check("core_start_pulse", 512'(core_start), 512'(1));
         check("core_message", core_message, m);
         check("s_ready_start", 512'(s_ready), 512'(0));
         check("busy_start", 512'(busy), 512'(1));
         step();
         check("core_start_drop", 512'(core_start), 512'(0));
         check("s_ready_wait", 512'(s_ready), 512'(0));
         check("word_count_wait", 512'(word_count), 512'(0));
         check("message_stable", core_message, m);
         s_valid = 1'b0;
      end
   endtask

   // Core stub from the first WAIT cycle through the ack.
   task automatic run_core(input int vdelay, input int hold, input int ackd,
                           input logic [255:0] h, input logic [255:0] exp_d);
      repeat (vdelay) begin
         core_hash = rnd256();
         step();
         check("dv_before_valid", 512'(digest_valid), 512'(0));
         check("busy_wait", 512'(busy), 512'(1));
      end
      core_valid = 1'b1;
      core_hash  = h;
      step();
      check("digest_valid_set", 512'(digest_valid), 512'(1));
      check("digest", 512'(digest), 512'(exp_d));
      check("busy_done", 512'(busy), 512'(0));
      for (int i = 1; i < hold; i++) begin
         core_hash = ~h;
         step();
         check("digest_single_capture", 512'(digest), 512'(exp_d));
      end
      core_valid = 1'b0;
      s_valid    = 1'b1;
      repeat (ackd) begin
         step();
         check("dv_held", 512'(digest_valid), 512'(1));
         check("digest_stable", 512'(digest), 512'(exp_d));
         check("s_ready_done", 512'(s_ready), 512'(0));
      end
      s_valid    = 1'b0;
      digest_ack = 1'b1;
      step();
      digest_ack = 1'b0;
      check("dv_cleared", 512'(digest_valid), 512'(0));
      check("s_ready_after_ack", 512'(s_ready), 512'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0]  w [16];
      logic [511:0] m;
      logic [255:0] h;
      vec_t         tbl [6];
      int           cyc;

      clr = 1'b1; s_valid = 1'b0; s_data = '0; abort = 1'b0;
      core_hash = '0; core_valid = 1'b0; digest_ack = 1'b0;
      step(); step();
      check_reset_outputs("reset");
      clr = 1'b0;
      step();

      // "abc" block, back-to-back
      for (int i = 0; i < 16; i++) w[i] = 32'h0;
      w[0]  = 32'h6162_6380;
      w[15] = 32'h0000_0018;
      send_words(w, 16, 1'b0, m);
      check("abc_block", m, {32'h6162_6380, 448'h0, 32'h0000_0018});
      h = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
      run_core(2, 1, 4, h, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

      // Randomized job table
      tbl[0] = '{gaps: 1'b1, vdelay: 0,   hold: 1, ackd: 0,  hash: rnd256(), exp_digest: '0};
      tbl[1] = '{gaps: 1'b1, vdelay: 3,   hold: 3, ackd: 10, hash: rnd256(), exp_digest: '0};
      tbl[2] = '{gaps: 1'b0, vdelay: 1,   hold: 3, ackd: 10, hash: rnd256(), exp_digest: '0};
      tbl[3] = '{gaps: 1'b1, vdelay: 200, hold: 2, ackd: 1,  hash: rnd256(), exp_digest: '0};
      tbl[4] = '{gaps: 1'b1, vdelay: 253, hold: 1, ackd: 2,  hash: rnd256(), exp_digest: '0};
      tbl[5] = '{gaps: 1'b1, vdelay: $urandom_range(0, 50), hold: $urandom_range(1, 4),
                 ackd: $urandom_range(0, 12), hash: rnd256(), exp_digest: '0};
      for (int t = 0; t < 6; t++) tbl[t].exp_digest = tbl[t].hash;
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 16; i++) w[i] = 32'($urandom);
         send_words(w, 16, tbl[t].gaps, m);
         run_core(tbl[t].vdelay, tbl[t].hold, tbl[t].ackd, tbl[t].hash, tbl[t].exp_digest);
      end

      // Timeout: core never answers
      for (int i = 0; i < 16; i++) w[i] = 32'($urandom);
      send_words(w, 16, 1'b1, m);
      cyc = 1;
      while (busy && cyc < 400) begin
         step();
         cyc++;
      end
      check("timeout_busy_cycles", 512'(cyc), 512'(TIMEOUT + 1));
      check("timeout_error", 512'(error), 512'(1));
      check("timeout_s_ready", 512'(s_ready), 512'(1));
      check("timeout_dv", 512'(digest_valid), 512'(0));
      repeat (3) step();
      check("error_sticky", 512'(error), 512'(1));
      for (int i = 0; i < 16; i++) w[i] = 32'($urandom);
      h = rnd256();
      send_words(w, 16, 1'b0, m);
      run_core(5, 1, 1, h, h);

      // Abort mid-load, then abort in WAIT against a simultaneous core_valid
      send_words(w, 7, 1'b1, m);
      abort = 1'b1; s_valid = 1'b1; s_data = 32'h1234_5678;
      step();
      abort = 1'b0; s_valid = 1'b0;
      check("abort_load_wc", 512'(word_count), 512'(0));
      check("abort_load_ready", 512'(s_ready), 512'(1));
      for (int i = 0; i < 16; i++) w[i] = 32'($urandom);
      send_words(w, 16, 1'b1, m);
      abort = 1'b1; core_valid = 1'b1; core_hash = rnd256();
      step();
      abort = 1'b0; core_valid = 1'b0;
      check("abort_wait_busy", 512'(busy), 512'(0));
      check("abort_wait_dv", 512'(digest_valid), 512'(0));
      check("abort_wait_ready", 512'(s_ready), 512'(1));
      check("abort_wait_wc", 512'(word_count), 512'(0));
      for (int i = 0; i < 16; i++) w[i] = 32'($urandom);
      h = rnd256();
      send_words(w, 16, 1'b0, m);
      run_core(4, 2, 3, h, h);

      // clr in WAIT, then a late core_valid must not produce a digest
      for (int i = 0; i < 16; i++) w[i] = 32'($urandom);
      send_words(w, 16, 1'b0, m);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check_reset_outputs("clr_wait");
      core_valid = 1'b1; core_hash = rnd256();
      repeat (3) begin
         step();
         check("late_valid_dv", 512'(digest_valid), 512'(0));
         check("late_valid_digest", 512'(digest), 512'(0));
      end
      core_valid = 1'b0;

      // clr in DONE
      for (int i = 0; i < 16; i++) w[i] = 32'($urandom);
      send_words(w, 16, 1'b1, m);
      core_valid = 1'b1; core_hash = rnd256();
      step();
      core_valid = 1'b0;
      check("pre_clr_dv", 512'(digest_valid), 512'(1));
      clr = 1'b1;
      step();
      clr = 1'b0;
      check_reset_outputs("clr_done");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
